rob_multi: RTL and testbench



---
 rtl/rob_multi.sv | 219 +++++++++++++++++++++
 tb/tb_rob_multi.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi.sv
// Parametrised reorder buffer: NUM_WB writeback channels, two forwarding query
// ports, in-order single commit, store-release handshake, flush on mispredict.
module rob_multi #(
    parameter int DEPTH  = 16,
    parameter int IDW    = $clog2(DEPTH),
    parameter int NUM_WB = 3,
    parameter int XLEN   = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rdy,
    input  logic                   i_alloc_valid,
    output logic                   o_alloc_ready,
    output logic [IDW-1:0]         o_alloc_id,
    input  logic [2:0]             i_alloc_kind,
    input  logic [4:0]             i_alloc_rd,
    input  logic [XLEN-1:0]        i_alloc_pc,
    input  logic [XLEN-1:0]        i_alloc_target,
    input  logic                   i_alloc_pred,
    input  logic [NUM_WB-1:0]      i_wb_valid,
    input  logic [NUM_WB*IDW-1:0]  i_wb_id,
    input  logic [NUM_WB*XLEN-1:0] i_wb_value,
    input  logic [NUM_WB*XLEN-1:0] i_wb_aux,
    input  logic [IDW-1:0]         i_q1_id,
    input  logic [IDW-1:0]         i_q2_id,
    output logic                   o_q1_ready,
    output logic                   o_q2_ready,
    output logic [XLEN-1:0]        o_q1_value,
    output logic [XLEN-1:0]        o_q2_value,
    output logic [IDW-1:0]         o_head_id,
    output logic [IDW:0]           o_count,
    output logic                   o_commit_valid,
    output logic [4:0]             o_commit_rd,
    output logic [IDW-1:0]         o_commit_id,
    output logic [XLEN-1:0]        o_commit_value,
    output logic                   o_st_commit_valid,
    input  logic                   i_st_commit_ready,
    output logic                   o_redirect_valid,
    output logic [XLEN-1:0]        o_redirect_pc,
    output logic                   o_flush,
    output logic                   o_bp_valid,
    output logic [XLEN-1:0]        o_bp_pc,
    output logic                   o_bp_taken,
    output logic                   o_bp_pred,
    output logic                   o_halt
);

    typedef enum logic [2:0] {
        KIND_REG    = 3'd0,
        KIND_BRANCH = 3'd1,
        KIND_JALR   = 3'd2,
        KIND_STORE  = 3'd3,
        KIND_HALT   = 3'd4
    } kind_e;

    localparam logic [IDW:0] FULL = (IDW+1)'(DEPTH);

    logic            r_busy   [DEPTH];
    logic            r_done   [DEPTH];
    kind_e           r_kind   [DEPTH];
    logic [4:0]      r_rd     [DEPTH];
    logic [XLEN-1:0] r_pc     [DEPTH];
    logic [XLEN-1:0] r_target [DEPTH];
    logic            r_pred   [DEPTH];
    logic [XLEN-1:0] r_value  [DEPTH];
    logic [XLEN-1:0] r_aux    [DEPTH];

    logic [IDW-1:0] r_head;
    logic [IDW-1:0] r_tail;
    logic [IDW:0]   r_count;

    logic  w_head_live;
    kind_e w_head_kind;
    logic  w_taken;
    logic  w_mispredict;
    logic  w_retire;
    logic  w_alloc_fire;

    assign w_head_live  = r_busy[r_head] && r_done[r_head] && !o_halt;
    assign w_head_kind  = r_kind[r_head];
    assign w_taken      = r_value[r_head][0];
    assign w_mispredict = w_head_live && (w_head_kind == KIND_BRANCH) &&
                          (w_taken != r_pred[r_head]);
    assign w_retire     = w_head_live &&
                          ((w_head_kind != KIND_STORE) || i_st_commit_ready);

    assign o_alloc_ready     = (r_count != FULL);
    assign o_alloc_id        = r_tail;
    assign o_head_id         = r_head;
    assign o_count           = r_count;
    assign o_st_commit_valid = w_head_live && (w_head_kind == KIND_STORE);
    assign w_alloc_fire      = i_alloc_valid && o_alloc_ready && !w_mispredict;

    // Descending scan so the lowest-numbered matching channel is applied last and wins.
    always_comb begin
        o_q1_ready = r_done[i_q1_id];
        o_q1_value = r_done[i_q1_id] ? r_value[i_q1_id] : '0;
        o_q2_ready = r_done[i_q2_id];
        o_q2_value = r_done[i_q2_id] ? r_value[i_q2_id] : '0;
        for (int c = NUM_WB - 1; c >= 0; c--) begin
            if (i_wb_valid[c] && (i_wb_id[c*IDW +: IDW] == i_q1_id)) begin
                o_q1_ready = 1'b1;
                o_q1_value = i_wb_value[c*XLEN +: XLEN];
            end
            if (i_wb_valid[c] && (i_wb_id[c*IDW +: IDW] == i_q2_id)) begin
                o_q2_ready = 1'b1;
                o_q2_value = i_wb_value[c*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i]   <= 1'b0;
                r_done[i]   <= 1'b0;
                r_kind[i]   <= KIND_REG;
                r_rd[i]     <= '0;
                r_pc[i]     <= '0;
                r_target[i] <= '0;
                r_pred[i]   <= 1'b0;
                r_value[i]  <= '0;
                r_aux[i]    <= '0;
            end
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            o_commit_valid   <= 1'b0;
            o_commit_rd      <= '0;
            o_commit_id      <= '0;
            o_commit_value   <= '0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_flush          <= 1'b0;
            o_bp_valid       <= 1'b0;
            o_bp_pc          <= '0;
            o_bp_taken       <= 1'b0;
            o_bp_pred        <= 1'b0;
            o_halt           <= 1'b0;
        end else if (i_rdy) begin
            o_commit_valid   <= 1'b0;
            o_redirect_valid <= 1'b0;
            o_flush          <= 1'b0;
            o_bp_valid       <= 1'b0;

            // Later channels overwrite earlier ones on an id clash.
            if (!w_mispredict) begin
                for (int c = 0; c < NUM_WB; c++) begin
                    if (i_wb_valid[c] && r_busy[i_wb_id[c*IDW +: IDW]]) begin
                        r_value[i_wb_id[c*IDW +: IDW]] <= i_wb_value[c*XLEN +: XLEN];
                        r_aux[i_wb_id[c*IDW +: IDW]]   <= i_wb_aux[c*XLEN +: XLEN];
                        r_done[i_wb_id[c*IDW +: IDW]]  <= 1'b1;
                    end
                end
            end

            if (w_retire) begin
                case (w_head_kind)
                    KIND_REG: begin
                        o_commit_valid <= (r_rd[r_head] != 5'd0);
                        o_commit_rd    <= r_rd[r_head];
                        o_commit_id    <= r_head;
                        o_commit_value <= r_value[r_head];
                    end
                    KIND_JALR: begin
                        o_commit_valid   <= (r_rd[r_head] != 5'd0);
                        o_commit_rd      <= r_rd[r_head];
                        o_commit_id      <= r_head;
                        o_commit_value   <= r_value[r_head];
                        o_redirect_valid <= 1'b1;
                        o_redirect_pc    <= r_aux[r_head];
                    end
                    KIND_BRANCH: begin
                        o_bp_valid <= 1'b1;
                        o_bp_pc    <= r_pc[r_head];
                        o_bp_taken <= w_taken;
                        o_bp_pred  <= r_pred[r_head];
                        if (w_mispredict) begin
                            o_redirect_valid <= 1'b1;
                            o_redirect_pc    <= w_taken ? r_target[r_head]
                                                        : r_pc[r_head] + XLEN'(4);
                            o_flush          <= 1'b1;
                        end
                    end
                    KIND_HALT: o_halt <= 1'b1;
                    default: ;
                endcase
            end

            if (w_mispredict) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_busy[i] <= 1'b0;
                    r_done[i] <= 1'b0;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_retire) begin
                    r_busy[r_head] <= 1'b0;
                    r_done[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                end
                if (w_alloc_fire) begin
                    r_busy[r_tail]   <= 1'b1;
                    r_done[r_tail]   <= 1'b0;
                    r_kind[r_tail]   <= kind_e'(i_alloc_kind);
                    r_rd[r_tail]     <= i_alloc_rd;
                    r_pc[r_tail]     <= i_alloc_pc;
                    r_target[r_tail] <= i_alloc_target;
                    r_pred[r_tail]   <= i_alloc_pred;
                    r_tail           <= r_tail + 1'b1;
                end
                r_count <= r_count + (IDW+1)'(w_alloc_fire) - (IDW+1)'(w_retire);
            end
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// Randomised and directed bench for rob_multi, checked against a queue-based
// model of the buffer in program order.
module tb_rob_multi;

    localparam int DEPTH  = 16;
    localparam int IDW    = 4;
    localparam int NUM_WB = 3;
    localparam int XLEN   = 32;

    logic                   clk, rst, rdy;
    logic                   allocValid, allocReady, allocPred;
    logic [IDW-1:0]         allocId, q1Id, q2Id, headId, commitId;
    logic [2:0]             allocKind;
    logic [4:0]             allocRd, commitRd;
    logic [XLEN-1:0]        allocPc, allocTarget;
    logic [NUM_WB-1:0]      wbValid;
    logic [NUM_WB*IDW-1:0]  wbIdBus;
    logic [NUM_WB*XLEN-1:0] wbValueBus, wbAuxBus;
    logic                   q1Ready, q2Ready;
    logic [XLEN-1:0]        q1Value, q2Value, commitValue, redirectPc, bpPc;
    logic [IDW:0]           count;
    logic                   commitValid, stCommitValid, stReady;
    logic                   redirectValid, flush, bpValid, bpTaken, bpPred, halt;

    logic [IDW-1:0]  wbIdArr  [NUM_WB];
    logic [XLEN-1:0] wbValArr [NUM_WB];
    logic [XLEN-1:0] wbAuxArr [NUM_WB];

    rob_multi #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .XLEN(XLEN)) dut (
        .i_clk(clk), .i_rst(rst), .i_rdy(rdy),
        .i_alloc_valid(allocValid), .o_alloc_ready(allocReady), .o_alloc_id(allocId),
        .i_alloc_kind(allocKind), .i_alloc_rd(allocRd), .i_alloc_pc(allocPc),
        .i_alloc_target(allocTarget), .i_alloc_pred(allocPred),
        .i_wb_valid(wbValid), .i_wb_id(wbIdBus), .i_wb_value(wbValueBus), .i_wb_aux(wbAuxBus),
        .i_q1_id(q1Id), .i_q2_id(q2Id),
        .o_q1_ready(q1Ready), .o_q2_ready(q2Ready), .o_q1_value(q1Value), .o_q2_value(q2Value),
        .o_head_id(headId), .o_count(count),
        .o_commit_valid(commitValid), .o_commit_rd(commitRd), .o_commit_id(commitId),
        .o_commit_value(commitValue),
        .o_st_commit_valid(stCommitValid), .i_st_commit_ready(stReady),
        .o_redirect_valid(redirectValid), .o_redirect_pc(redirectPc), .o_flush(flush),
        .o_bp_valid(bpValid), .o_bp_pc(bpPc), .o_bp_taken(bpTaken), .o_bp_pred(bpPred),
        .o_halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int          kind;
        int          rd;
        logic [31:0] pc;
        logic [31:0] target;
        bit          pred;
        bit          done;
        logic [31:0] value;
        logic [31:0] aux;
    } entry_t;

    // Model: the live entries in program order, oldest first.
    entry_t      rob[$];
    int          tailId;
    bit          halted;
    bit          eCommitValid, eRedirValid, eFlush, eBpValid, eBpTaken, eBpPred;
    int          eCommitRd, eCommitId;
    logic [31:0] eCommitValue, eRedirPc, eBpPc;

    int vectorCount = 0;
    int missCount   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        rob.delete();
        tailId = 0; halted = 0;
        eCommitValid = 0; eRedirValid = 0; eFlush = 0; eBpValid = 0;
    endtask

    task automatic setIdle();
        rdy = 1; allocValid = 0; allocKind = 0; allocRd = 0; allocPc = 0;
        allocTarget = 0; allocPred = 0; stReady = 0; q1Id = 0; q2Id = 0;
        for (int c = 0; c < NUM_WB; c++) begin
            wbValid[c] = 0; wbIdArr[c] = 0; wbValArr[c] = 0; wbAuxArr[c] = 0;
        end
    endtask

    task automatic driveInputs();
        for (int c = 0; c < NUM_WB; c++) begin
            wbIdBus[c*IDW +: IDW]     = wbIdArr[c];
            wbValueBus[c*XLEN +: XLEN] = wbValArr[c];
            wbAuxBus[c*XLEN +: XLEN]   = wbAuxArr[c];
        end
    endtask

    task automatic modelQuery(input int qid, output bit ready, output logic [31:0] value);
        bit found = 0;
        ready = 0; value = 0;
        for (int c = 0; c < NUM_WB; c++)
            if (!found && wbValid[c] && int'(wbIdArr[c]) == qid) begin
                found = 1; ready = 1; value = wbValArr[c];
            end
        if (!found)
            foreach (rob[i])
                if (rob[i].id == qid && rob[i].done) begin
                    ready = 1; value = rob[i].value;
                end
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic applyStimulus();
        bit          qr, retire, misp, taken;
        logic [31:0] qv;
        entry_t      h, e;
        int          sizeBefore;
        driveInputs();
        #1;
        checkOutput("allocReady", allocReady, rob.size() != DEPTH);
        checkOutput("allocId", allocId, tailId);
        checkOutput("headId", headId, (rob.size() > 0) ? rob[0].id : tailId);
        checkOutput("count", count, rob.size());
        modelQuery(int'(q1Id), qr, qv);
        checkOutput("q1Ready", q1Ready, qr);
        checkOutput("q1Value", q1Value, qv);
        modelQuery(int'(q2Id), qr, qv);
        checkOutput("q2Ready", q2Ready, qr);
        checkOutput("q2Value", q2Value, qv);
        checkOutput("stCommitValid", stCommitValid,
                    !halted && rob.size() > 0 && rob[0].done && rob[0].kind == 3);

        if (rdy) begin
            eCommitValid = 0; eRedirValid = 0; eFlush = 0; eBpValid = 0;
            retire = 0; misp = 0;
            if (!halted && rob.size() > 0 && rob[0].done) begin
                h = rob[0];
                case (h.kind)
                    0, 2: begin
                        retire = 1;
                        if (h.rd != 0) begin
                            eCommitValid = 1; eCommitRd = h.rd;
                            eCommitId = h.id; eCommitValue = h.value;
                        end
                        if (h.kind == 2) begin eRedirValid = 1; eRedirPc = h.aux; end
                    end
                    1: begin
                        retire = 1; taken = h.value[0];
                        eBpValid = 1; eBpPc = h.pc; eBpTaken = taken; eBpPred = h.pred;
                        if (taken != h.pred) begin
                            misp = 1; eFlush = 1; eRedirValid = 1;
                            eRedirPc = taken ? h.target : h.pc + 32'd4;
                        end
                    end
                    3: retire = stReady;
                    default: begin retire = 1; halted = 1; end
                endcase
            end
            sizeBefore = rob.size();
            if (misp) begin
                rob.delete();
                tailId = 0;
            end else begin
                for (int c = 0; c < NUM_WB; c++)
                    if (wbValid[c])
                        foreach (rob[i])
                            if (rob[i].id == int'(wbIdArr[c])) begin
                                e = rob[i]; e.done = 1; e.value = wbValArr[c]; e.aux = wbAuxArr[c];
                                rob[i] = e;
                            end
                if (retire) void'(rob.pop_front());
                if (allocValid && sizeBefore != DEPTH) begin
                    e = '{id: tailId, kind: int'(allocKind), rd: int'(allocRd), pc: allocPc,
                          target: allocTarget, pred: allocPred, done: 0, value: 0, aux: 0};
                    rob.push_back(e);
                    tailId = (tailId + 1) % DEPTH;
                end
            end
        end

        @(posedge clk);
        #1;
        checkOutput("commitValid", commitValid, eCommitValid);
        if (eCommitValid) begin
            checkOutput("commitRd", commitRd, eCommitRd);
            checkOutput("commitId", commitId, eCommitId);
            checkOutput("commitValue", commitValue, eCommitValue);
        end
        checkOutput("redirectValid", redirectValid, eRedirValid);
        if (eRedirValid) checkOutput("redirectPc", redirectPc, eRedirPc);
        checkOutput("flush", flush, eFlush);
        checkOutput("bpValid", bpValid, eBpValid);
        if (eBpValid) begin
            checkOutput("bpPc", bpPc, eBpPc);
            checkOutput("bpTaken", bpTaken, eBpTaken);
            checkOutput("bpPred", bpPred, eBpPred);
        end
        checkOutput("halt", halt, halted);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1;
        setIdle();
        driveInputs();
        #1;
        modelReset();
        checkOutput("rstCount", count, 0);
        checkOutput("rstAllocReady", allocReady, 1);
        checkOutput("rstCommitValid", commitValid, 0);
        checkOutput("rstCommitValue", commitValue, 0);
        checkOutput("rstRedirect", {redirectValid, redirectPc}, 0);
        checkOutput("rstFlush", flush, 0);
        checkOutput("rstBp", {bpValid, bpPc}, 0);
        checkOutput("rstHalt", halt, 0);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic allocOne(input int kind, input int rd, input logic [31:0] pc,
                            input logic [31:0] target, input bit pred);
        setIdle();
        allocValid = 1; allocKind = 3'(kind); allocRd = 5'(rd);
        allocPc = pc; allocTarget = target; allocPred = pred;
        applyStimulus();
    endtask

    task automatic randomCycle();
        int r;
        setIdle();
        rdy        = ($urandom_range(0, 9) != 0);
        allocValid = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        allocKind   = (r < 5) ? 3'd0 : (r < 7) ? 3'd1 : (r < 8) ? 3'd2 : 3'd3;
        allocRd     = 5'($urandom_range(0, 31));
        allocPc     = $urandom & 32'hFFFF_FFFC;
        allocTarget = $urandom & 32'hFFFF_FFFC;
        allocPred   = 1'($urandom_range(0, 1));
        stReady     = 1'($urandom_range(0, 1));
        for (int c = 0; c < NUM_WB; c++) begin
            wbValid[c] = 1'($urandom_range(0, 1));
            if (rob.size() > 0 && $urandom_range(0, 7) != 0)
                wbIdArr[c] = IDW'(rob[$urandom_range(0, rob.size() - 1)].id);
            else
                wbIdArr[c] = IDW'($urandom_range(0, DEPTH - 1));
            wbValArr[c] = $urandom;
            wbAuxArr[c] = $urandom;
        end
        q1Id = ($urandom_range(0, 1) != 0) ? wbIdArr[$urandom_range(0, NUM_WB - 1)]
                                           : IDW'($urandom_range(0, DEPTH - 1));
        q2Id = IDW'($urandom_range(0, DEPTH - 1));
    endtask

    initial begin
        rst = 1;
        setIdle();
        driveInputs();
        @(negedge clk);
        doReset();

        $display("[TB] fill, overflow attempt, out-of-order writeback, wrap");
        for (int i = 0; i < DEPTH; i++) allocOne(0, i + 1, 32'h1000 + 32'(4 * i), 0, 0);
        checkOutput("fullAllocReady", allocReady, 0);
        checkOutput("fullCount", count, DEPTH);
        allocOne(0, 30, 32'h2000, 0, 0);
        setIdle();
        wbValid = '1;
        wbIdArr[0] = 2; wbIdArr[1] = 1; wbIdArr[2] = 0;
        wbValArr[0] = 32'hA2; wbValArr[1] = 32'hA1; wbValArr[2] = 32'hA0;
        applyStimulus();
        for (int i = 0; i < DEPTH + 4; i++) begin
            setIdle();
            allocValid = 1; allocRd = 5'(i + 7);
            wbValid[0] = 1; wbIdArr[0] = IDW'(i + 3); wbValArr[0] = 32'(i * 17 + 5);
            applyStimulus();
        end

        $display("[TB] same-cycle forwarding");
        doReset();
        for (int i = 0; i < 6; i++) allocOne(0, i + 1, 0, 0, 0);
        setIdle();
        wbValid[1] = 1; wbIdArr[1] = 5; wbValArr[1] = 32'hDEAD; q1Id = 5;
        driveInputs();
        #1;
        checkOutput("fwdReady", q1Ready, 1);
        checkOutput("fwdValue", q1Value, 32'hDEAD);
        applyStimulus();
        setIdle(); q1Id = 5; q2Id = 4;
        applyStimulus();

        $display("[TB] branch mispredict");
        doReset();
        allocOne(1, 0, 32'h100, 32'h180, 0);
        allocOne(0, 3, 32'h104, 0, 0);
        setIdle();
        wbValid = 3'b011; wbIdArr[0] = 0; wbValArr[0] = 1; wbIdArr[1] = 1; wbValArr[1] = 32'h55;
        applyStimulus();
        for (int i = 0; i < 4; i++) begin setIdle(); applyStimulus(); end

        $display("[TB] store handshake");
        doReset();
        allocOne(3, 0, 32'h200, 0, 0);
        setIdle(); wbValid[2] = 1; wbIdArr[2] = 0; wbValArr[2] = 32'h77;
        applyStimulus();
        for (int i = 0; i < 3; i++) begin setIdle(); applyStimulus(); end
        setIdle(); stReady = 1; applyStimulus();
        setIdle(); applyStimulus();

        $display("[TB] randomised traffic");
        doReset();
        for (int i = 0; i < 3000; i++) begin
            randomCycle();
            applyStimulus();
        end

        $display("[TB] JALR then HALT");
        doReset();
        allocOne(2, 1, 32'h100, 0, 0);
        allocOne(4, 0, 32'h104, 0, 0);
        allocOne(0, 2, 32'h108, 0, 0);
        setIdle();
        wbValid = '1;
        wbIdArr[0] = 0; wbValArr[0] = 32'h104; wbAuxArr[0] = 32'h200;
        wbIdArr[1] = 1; wbIdArr[2] = 2; wbValArr[2] = 32'h99;
        applyStimulus();
        for (int i = 0; i < 6; i++) begin setIdle(); applyStimulus(); end
        checkOutput("haltSticky", halt, 1);

        $display("[TB] asynchronous reset between edges");
        #2;
        rst = 1;
        #1;
        checkOutput("asyncHalt", halt, 0);
        checkOutput("asyncCount", count, 0);
        modelReset();
        @(negedge clk);
        rst = 0;
        setIdle();
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
